// File: rtl/bitmap_row_scanner.sv
// Fetches a frame from a registered bitmap ROM one row at a time and streams it MSB-first
// as a 1-bit pixel stream with valid/ready handshake and start/end-of-line/frame markers.
module bitmap_row_scanner #(
  parameter int ROWS   = 32,
  parameter int COLS   = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COLS-1:0]   rom_data,
  output logic              pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] row;
  logic [COL_W-1:0]  col;
  logic [COLS-1:0]   shreg;
  logic              in_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      shreg     <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      pix_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      rom_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row      <= '0;
            rom_addr <= '0;
            rom_en   <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          // The ROM word is registered: it appears the cycle after the fetch.
          shreg     <= rom_data;
          col       <= '0;
          pix_valid <= 1'b1;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (pix_valid && pix_ready) begin
            shreg <= {shreg[COLS-2:0], 1'b0};
            if (col == COL_LAST) begin
              pix_valid <= 1'b0;
              if (row == ROW_LAST) begin
                done  <= 1'b1;
                state <= S_FIN;
              end else begin
                row      <= row + 1'b1;
                rom_addr <= row + 1'b1;
                rom_en   <= 1'b1;
                state    <= S_FETCH;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Markers derive from the held row/col, so they stay stable through a stall.
  assign in_shift = (state == S_SHIFT);
  assign busy     = (state != S_IDLE);
  assign pix_data = in_shift & shreg[COLS-1];
  assign pix_sol  = in_shift && (col == '0);
  assign pix_eol  = in_shift && (col == COL_LAST);
  assign pix_sof  = pix_sol && (row == '0);
  assign pix_eof  = pix_eol && (row == ROW_LAST);

endmodule

// File: tb/tb_bitmap_row_scanner.sv
// Directed bench for bitmap_row_scanner with a registered 32x64 ROM model as source.
module tb_bitmap_row_scanner;
  localparam int ROWS   = 32;
  localparam int COLS   = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              pix_ready = 1'b0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [COLS-1:0]   rom_data;
  logic              pix_data, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, busy, done;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] got [ROWS];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROM: registered output, zero when not enabled.
  always @(posedge clk) rom_data <= rom_en ? mem[rom_addr] : '0;

  bitmap_row_scanner #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outs"},
        {55'd0, rom_en, pix_data, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, busy, done}, 64'd0);
  endtask

  // rnd: random ready plus a forced 10-cycle stall at row 5 col 30.
  // poke: pulse start at cycle 500. abort_row >= 0: assert rst mid-row in that row.
  task automatic run_frame(input bit rnd, input bit poke, input int abort_row);
    int   cyc = 0;
    int   beats = 0;
    int   fetches = 0;
    int   dones = 0;
    int   done_cyc = -1;
    int   stall = 0;
    int   r, c;
    bit   stalled_once = 0;
    bit   prev_stall = 0;
    bit   prev_en = 0;
    bit   finished = 0;
    logic [4:0] prev_flags = '0;

    for (int i = 0; i < ROWS; i++) got[i] = '0;
    @(posedge clk); #1;
    start = 1'b1;
    pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

    while (cyc < 20000 && !finished) begin
      @(negedge clk);
      if (rom_en) begin
        chk("rom_addr_order", 64'(rom_addr), 64'(fetches));
        chk("rom_en_single", 64'(prev_en), 64'd0);
        if (!rnd) chk("fetch_cycle", 64'(cyc), 64'(1 + (COLS + 2) * fetches));
        fetches++;
      end
      prev_en = rom_en;
      if (prev_stall)
        chk("stall_hold", {58'd0, pix_valid, pix_data, pix_sol, pix_eol, pix_sof, pix_eof},
            {58'd0, 1'b1, prev_flags});
      if (pix_valid && beats < ROWS * COLS) begin
        r = beats / COLS;
        c = beats % COLS;
        chk("pix_data", 64'(pix_data), 64'(mem[r][COLS-1-c]));
        chk("markers", {60'd0, pix_sol, pix_eol, pix_sof, pix_eof},
            {60'd0, c == 0, c == COLS - 1, beats == 0, beats == ROWS * COLS - 1});
        if (pix_ready) begin
          got[r][COLS-1-c] = pix_data;
          if (!rnd) chk("beat_cycle", 64'(cyc), 64'(3 + (COLS + 2) * r + c));
          beats++;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_flags = {pix_data, pix_sol, pix_eol, pix_sof, pix_eof};
      if (done) begin
        dones++;
        if (dones == 1) done_cyc = cyc;
      end
      if (dones > 0 && cyc == done_cyc + 3) finished = 1;

      @(posedge clk); #1;
      start = poke && (cyc + 1 == 500);
      if (rnd) begin
        if (stall > 0) begin
          pix_ready = 1'b0;
          stall--;
        end else if (beats == 5 * COLS + 30 && !stalled_once) begin
          stalled_once = 1;
          pix_ready = 1'b0;
          stall = 9;
        end else begin
          pix_ready = 1'($urandom_range(0, 1));
        end
      end
      if (abort_row >= 0 && beats == abort_row * COLS + 20) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk_quiet("abort");
        chk("abort_rom_addr", 64'(rom_addr), 64'd0);
        rst = 1'b0;
        pix_ready = 1'b1;
        finished = 1;
      end
      cyc++;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    chk("no_timeout", 64'(finished), 64'd1);

    if (abort_row < 0) begin
      chk("beat_count", 64'(beats), 64'(ROWS * COLS));
      chk("fetch_count", 64'(fetches), 64'(ROWS));
      chk("done_count", 64'(dones), 64'd1);
      if (!rnd) chk("done_cycle", 64'(done_cyc), 64'd2113);
      chk("busy_after", 64'(busy), 64'd0);
      chk("rom_addr_hold", 64'(rom_addr), 64'(ROWS - 1));
      for (int i = 0; i < ROWS; i++) chk("row_image", got[i], mem[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < ROWS; i++)
      mem[i] = {32'(i) * 32'h9E3779B9, ~(32'(i) * 32'h85EBCA6B)};
    mem[0]         = '0;
    mem[17][63:59] = 5'b11110;
    mem[4][41]     = 1'b1;

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_quiet("after_reset");
    chk("reset_rom_addr", 64'(rom_addr), 64'd0);

    // Full frame, ready held high.
    run_frame(1'b0, 1'b0, -1);
    chk("row0_zero", got[0], 64'd0);
    chk("row17_head", {59'd0, got[17][63:59]}, 64'b11110);
    chk("row4_beat22", 64'(got[4][41]), 64'd1);

    // Random backpressure with a long stall.
    run_frame(1'b1, 1'b0, -1);

    // Start pulse while busy is ignored.
    run_frame(1'b0, 1'b1, -1);

    // Abort mid-row 10, then a fresh frame.
    run_frame(1'b0, 1'b0, 10);
    @(posedge clk); #1;
    chk_quiet("idle_after_abort");
    run_frame(1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
